// File: rtl/femto_uart_pkg.sv
// Shared register map, STATUS bit layout and transmitter state encoding
// for the femto iomem UART transmitter.
package femto_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_COUNT    = 4;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A divisor of 0 or 1 cannot time a bit, so it is raised to the minimum.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/femto_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module femto_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/femto_iomem_uart_tx.sv
// iomem-mapped UART transmitter: DATA/STATUS/DIV registers, TX FIFO, 8N1 framer.
// state   | meaning
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) for shadow-DIV cycles
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high); chains straight into the next frame if queued
module femto_iomem_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 210,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tx
);
  import femto_uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, accept, wr_en;
  logic [1:0]    reg_sel;
  logic [15:0]   div_q, div_wr;
  logic          overflow_q;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [4:0]    count_ext;
  logic [31:0]   status_word, rdata_mux;
  tx_state_t     state_q, state_n;
  logic [15:0]   cyc_q, cyc_n, shadow_q, shadow_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shreg_q, shreg_n;
  logic          tx_q, tx_n, start_frame;
  logic          unused_bits;

  assign hit       = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign accept    = hit && !iomem_ready;
  assign wr_en     = accept && (iomem_wstrb != 4'b0);
  assign reg_sel   = iomem_addr[3:2];
  assign fifo_push = wr_en && (reg_sel == REG_DATA) && iomem_wstrb[0];
  assign count_ext = 5'(fifo_count);
  assign div_wr    = {iomem_wstrb[1] ? iomem_wdata[15:8] : div_q[15:8],
                      iomem_wstrb[0] ? iomem_wdata[7:0]  : div_q[7:0]};
  assign tx        = tx_q;
  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2], count_ext[4]};

  always_comb begin
    status_word                          = '0;
    status_word[ST_BUSY]                 = (state_q != S_IDLE);
    status_word[ST_FULL]                 = fifo_full;
    status_word[ST_EMPTY]                = fifo_empty;
    status_word[ST_OVERFLOW]             = overflow_q;
    status_word[ST_COUNT+3:ST_COUNT]     = count_ext[3:0];
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_sel)
      REG_STATUS: rdata_mux = status_word;
      REG_DIV:    rdata_mux = {16'b0, div_q};
      REG_RSVD:   rdata_mux = '0;
      default:    rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      div_q       <= 16'(DEFAULT_DIV);
      overflow_q  <= 1'b0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rdata_mux : 32'b0;
      if (fifo_push && fifo_full && !fifo_pop)
        overflow_q <= 1'b1;
      else if (wr_en && (reg_sel == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[ST_OVERFLOW])
        overflow_q <= 1'b0;
      if (wr_en && (reg_sel == REG_DIV) && (iomem_wstrb[1:0] != 2'b00))
        div_q <= clamp_div(div_wr);
    end
  end

  femto_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (iomem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bit timer is a down-counter; each bit ends on its terminal count of zero.
  always_comb begin
    state_n     = state_q;
    cyc_n       = cyc_q;
    bit_n       = bit_q;
    shreg_n     = shreg_q;
    shadow_n    = shadow_q;
    tx_n        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_n        = 1'b1;
        start_frame = !fifo_empty;
      end
      S_START: begin
        if (cyc_q == 16'd0) begin
          state_n = S_DATA;
          cyc_n   = shadow_q - 16'd1;
          bit_n   = 3'd0;
          tx_n    = shreg_q[0];
        end else begin
          cyc_n = cyc_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cyc_q == 16'd0) begin
          cyc_n = shadow_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_q + 3'd1;
            shreg_n = {1'b0, shreg_q[7:1]};
            tx_n    = shreg_q[1];
          end
        end else begin
          cyc_n = cyc_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cyc_q == 16'd0) begin
          start_frame = !fifo_empty;
          state_n     = S_IDLE;
          tx_n        = 1'b1;
        end else begin
          cyc_n = cyc_q - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The divisor is captured per frame so mid-frame DIV writes wait for the next one.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shreg_n  = fifo_rdata;
      shadow_n = div_q;
      cyc_n    = div_q - 16'd1;
      bit_n    = 3'd0;
      tx_n     = 1'b0;
      state_n  = S_START;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_n;
      cyc_q    <= cyc_n;
      bit_q    <= bit_n;
      shreg_q  <= shreg_n;
      shadow_q <= shadow_n;
      tx_q     <= tx_n;
    end
  end

endmodule

// File: tb/tb_femto_iomem_uart_tx.sv
// Scoreboard bench for femto_iomem_uart_tx: bus reads and serial frames are
// queued as expectations by the stimulus and checked by independent monitors.
module tb_femto_iomem_uart_tx;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [3:0]  OFF_DATA = 4'h0, OFF_STATUS = 4'h4, OFF_DIV = 4'h8, OFF_RSVD = 4'hC;
  localparam logic [31:0] NO_FULL = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        tx;

  femto_iomem_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(210), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         abort;
  } frame_t;

  rd_exp_t rdq[$];
  frame_t  txq[$];
  int      n_checks = 0;
  int      n_pass = 0;
  int      frames_done = 0;
  int      acks;
  rd_exp_t mon_rd;
  frame_t  mon_fr;
  logic [9:0] mon_bits;
  bit      mon_aborted;
  bit      mon_bit_ok;
  logic [7:0] burst [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h7E, 8'hEE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d);
    int t;
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = d;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (iomem_ready !== 1'b1 && t < 20);
    if (iomem_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL bus_timeout: addr %h got no ready expected ready", addr);
    end
    iomem_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] strb, input logic [31:0] d);
    bus(BASE + {28'b0, off}, strb, d);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input logic [31:0] mask, input string name);
    rd_exp_t e;
    e.exp = exp; e.mask = mask; e.name = name;
    rdq.push_back(e);
    bus(BASE + {28'b0, off}, 4'b0, 32'b0);
  endtask

  task automatic exp_frame(input logic [7:0] d, input int div, input bit abort);
    frame_t f;
    f.data = d; f.div = div; f.abort = abort;
    txq.push_back(f);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("frames_done", frames_done, n);
  endtask

  // Bus monitor: every acknowledged read is matched against the next queued expectation.
  initial begin : bus_mon
    forever begin
      @(negedge clk);
      if (iomem_ready === 1'b1) begin
        if (iomem_wstrb == 4'b0) begin
          if (rdq.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_read_ack: got ready expected none outstanding");
          end else begin
            mon_rd = rdq.pop_front();
            check(mon_rd.name, iomem_rdata & mon_rd.mask, mon_rd.exp & mon_rd.mask);
          end
        end
        @(negedge clk);
        check("ready_one_cycle", {31'b0, iomem_ready}, 32'b0);
      end
    end
  end

  // Serial monitor: each bit of an expected frame must hold for exactly div cycles.
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      if (txq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: got start bit expected idle line");
        do @(negedge clk); while (tx === 1'b0 && reset === 1'b0);
        continue;
      end
      mon_fr      = txq.pop_front();
      mon_bits    = {1'b1, mon_fr.data, 1'b0};
      mon_aborted = 1'b0;
      for (int b = 0; b < 10 && !mon_aborted; b++) begin
        mon_bit_ok = 1'b1;
        for (int c = 0; c < mon_fr.div; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset === 1'b1) begin
            mon_aborted = 1'b1;
            check("tx_high_in_reset", {31'b0, tx}, 32'd1);
            break;
          end
          if (tx !== mon_bits[b]) mon_bit_ok = 1'b0;
        end
        if (!mon_aborted) begin
          n_checks++;
          if (mon_bit_ok) n_pass++;
          else $display("FAIL frame_bit: byte %h bit %0d div %0d got unsteady/wrong tx expected %b",
                        mon_fr.data, b, mon_fr.div, mon_bits[b]);
        end
      end
      check("frame_abort", {31'b0, mon_aborted}, {31'b0, mon_fr.abort});
      if (mon_aborted) begin
        while (reset === 1'b1) @(negedge clk);
      end else begin
        frames_done++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    iomem_addr  = 32'b0;
    iomem_wdata = 32'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_ready", {31'b0, iomem_ready}, 32'd0);
    check("reset_rdata", iomem_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    rd(OFF_STATUS, 32'h04, '1, "status_reset");
    rd(OFF_DIV, 32'd210, '1, "div_reset");

    // Single 0x55 frame at DIV=4, starting one cycle after the write is acknowledged.
    wr(OFF_DIV, 4'b0011, 32'd4);
    exp_frame(8'h55, 4, 1'b0);
    wr(OFF_DATA, 4'b0001, 32'h55);
    @(negedge clk);
    check("tx_high_at_ack", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("tx_low_after_ack", {31'b0, tx}, 32'd0);
    repeat (8) @(posedge clk);
    rd(OFF_STATUS, 32'h05, '1, "status_busy");
    wait_frames(1, 100);
    repeat (2) @(posedge clk);
    rd(OFF_STATUS, 32'h04, '1, "status_idle_after_frame");

    // Burst of nine: one in flight, eight queued; a tenth overflows and is dropped.
    for (int i = 0; i < 9; i++) begin
      exp_frame(burst[i], 4, 1'b0);
      wr(OFF_DATA, 4'b0001, {24'b0, burst[i]});
    end
    rd(OFF_STATUS, 32'h81, NO_FULL, "status_fifo_8");
    wr(OFF_DATA, 4'b0001, {24'b0, burst[9]});
    rd(OFF_STATUS, 32'h89, NO_FULL, "status_overflow");
    wr(OFF_STATUS, 4'b0001, 32'h8);
    rd(OFF_STATUS, 32'h81, NO_FULL, "status_ovf_cleared");
    wait_frames(10, 600);

    // Divisor write strobes and minimum clamp.
    wr(OFF_DIV, 4'b0011, 32'd1);
    rd(OFF_DIV, 32'd2, '1, "div_min_clamp");
    wr(OFF_DIV, 4'b0011, 32'd4);
    wr(OFF_DIV, 4'b0010, 32'h0010);
    rd(OFF_DIV, 32'h0004, '1, "div_high_strobe");
    wr(OFF_DIV, 4'b0001, 32'h1234);
    rd(OFF_DIV, 32'h0034, '1, "div_low_strobe");
    wr(OFF_DIV, 4'b0011, 32'd4);

    // DIV changed during data bit 2 of 0xA3 only affects the following frame.
    exp_frame(8'hA3, 4, 1'b0);
    exp_frame(8'h96, 8, 1'b0);
    wr(OFF_DATA, 4'b0001, 32'hA3);
    wr(OFF_DATA, 4'b0001, 32'h96);
    repeat (10) @(posedge clk);
    wr(OFF_DIV, 4'b0011, 32'd8);
    rd(OFF_DIV, 32'd8, '1, "div_midframe");
    wait_frames(12, 300);
    wr(OFF_DIV, 4'b0011, 32'd4);

    // Address decode: foreign address never acknowledged; reserved offset reads 0.
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) acks++;
    end
    @(posedge clk); #1;
    iomem_valid = 1'b0;
    check("nonhit_no_ready", acks, 0);
    rd(OFF_RSVD, 32'h0, '1, "rsvd_read");
    wr(OFF_RSVD, 4'b1111, 32'hFFFF_FFFF);
    rd(OFF_DIV, 32'd4, '1, "div_after_rsvd_write");
    rd(OFF_DATA, 32'h0, '1, "data_read_zero");

    // Reset during data bit 5 with three bytes queued behind the active frame.
    exp_frame(8'h11, 4, 1'b1);
    wr(OFF_DATA, 4'b0001, 32'h11);
    wr(OFF_DATA, 4'b0001, 32'h22);
    wr(OFF_DATA, 4'b0001, 32'h33);
    wr(OFF_DATA, 4'b0001, 32'h44);
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd(OFF_STATUS, 32'h04, '1, "status_after_reset");
    rd(OFF_DIV, 32'd210, '1, "div_after_reset");
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("tx_idle_after_reset", {31'b0, tx}, 32'd1);
    check("frames_after_reset", frames_done, 12);
    check("txq_drained", txq.size(), 0);
    check("rdq_drained", rdq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
